// File: rtl/charger_stat_gen.sv
// Behavioural charger model driving the single-wire STAT line: low while charging,
// high when idle/done, square-wave blink on a latched fault.
module charger_stat_gen #(
  parameter int BLINK_HALF = 4096,
  parameter int DEB        = 16,
  parameter int TERM_DLY   = 8,
  parameter int TIMEOUT    = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       usb_i,
  input  logic       level_i,
  input  logic       fault_in_i,
  output logic       stat_o,
  output logic       chg_en_o,
  output logic [1:0] state_o
);

  // state  | meaning
  // OFF    | no qualified USB, STAT high, charging off
  // CHARGE | charge current on, STAT low, safety timer running
  // DONE   | battery full, STAT high, waiting for level to drop
  // FAULT  | latched fault, STAT blinks, exit only by unplugging USB
  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_CHARGE = 2'b01,
    S_DONE   = 2'b10,
    S_FAULT  = 2'b11
  } state_t;

  localparam int DW = $clog2(DEB + 1);
  localparam int LW = $clog2(TERM_DLY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEB);
  localparam logic [DW-1:0] DEB_M1  = DW'(DEB - 1);
  localparam logic [LW-1:0] TD_MAX  = LW'(TERM_DLY);
  localparam logic [LW-1:0] TD_M1   = LW'(TERM_DLY - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BH_M1   = BW'(BLINK_HALF - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          usb_ok_q, usb_ok_d;
  logic [LW-1:0] lvl_cnt_q, lvl_cnt_d;
  logic [TW-1:0] chg_timer_q, chg_timer_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          stat_q, stat_d;
  logic          chg_en_q, chg_en_d;
  logic          entering;
  logic          lvl_match;
  logic          lvl_held;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_OFF;
      deb_cnt_q   <= '0;
      usb_ok_q    <= 1'b0;
      lvl_cnt_q   <= '0;
      chg_timer_q <= '0;
      blink_cnt_q <= '0;
      stat_q      <= 1'b1;
      chg_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      usb_ok_q    <= usb_ok_d;
      lvl_cnt_q   <= lvl_cnt_d;
      chg_timer_q <= chg_timer_d;
      blink_cnt_q <= blink_cnt_d;
      stat_q      <= stat_d;
      chg_en_q    <= chg_en_d;
    end
  end

  // Plug-in is debounced; removal drops usb_ok on the first low sample.
  always_comb begin
    deb_cnt_d = '0;
    usb_ok_d  = 1'b0;
    if (usb_i) begin
      deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DW'(1);
      usb_ok_d  = usb_ok_q || (deb_cnt_q >= DEB_M1);
    end
  end

  always_comb begin
    lvl_match = ((state_q == S_CHARGE) && level_i) || ((state_q == S_DONE) && !level_i);
    lvl_held  = lvl_match && (lvl_cnt_q >= TD_M1);
    state_d   = state_q;
    case (state_q)
      S_OFF: begin
        if (usb_ok_q) begin
          if (fault_in_i)   state_d = S_FAULT;
          else if (level_i) state_d = S_DONE;
          else              state_d = S_CHARGE;
        end
      end
      S_CHARGE: begin
        if (!usb_ok_q)                   state_d = S_OFF;
        else if (fault_in_i)             state_d = S_FAULT;
        else if (chg_timer_q == TMO_M1)  state_d = S_FAULT;
        else if (lvl_held)               state_d = S_DONE;
      end
      S_DONE: begin
        if (!usb_ok_q)       state_d = S_OFF;
        else if (fault_in_i) state_d = S_FAULT;
        else if (lvl_held)   state_d = S_CHARGE;
      end
      S_FAULT: begin
        if (!usb_ok_q) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Counters and registered outputs follow the next state so everything moves together.
  always_comb begin
    entering    = (state_d != state_q);
    lvl_cnt_d   = '0;
    chg_timer_d = '0;
    blink_cnt_d = '0;
    stat_d      = 1'b1;
    chg_en_d    = (state_d == S_CHARGE);

    if (!entering && lvl_match)
      lvl_cnt_d = (lvl_cnt_q == TD_MAX) ? lvl_cnt_q : lvl_cnt_q + LW'(1);

    if (!entering && (state_q == S_CHARGE))
      chg_timer_d = (chg_timer_q == TMO_MAX) ? chg_timer_q : chg_timer_q + TW'(1);

    case (state_d)
      S_CHARGE: stat_d = 1'b0;
      S_FAULT: begin
        if (entering) begin
          stat_d = 1'b0;
        end else if (blink_cnt_q == BH_M1) begin
          stat_d = ~stat_q;
        end else begin
          stat_d      = stat_q;
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
      default: stat_d = 1'b1;
    endcase
  end

  assign stat_o   = stat_q;
  assign chg_en_o = chg_en_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_charger_stat_gen.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus compared every cycle against an event/age-based model of the charger.
module tb_charger_stat_gen;

  localparam int BH  = 4;
  localparam int DEB = 3;
  localparam int TD  = 2;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst, usb, level, fault_in;
  logic       stat, chg_en;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Model: state as 0..3, run lengths and ages in plain integers.
  int m_state = 0;
  int m_run   = 0;
  int m_lvl   = 0;
  int m_age   = 0;
  bit m_ok    = 1'b0;
  bit m_stat  = 1'b1;
  bit m_chg   = 1'b0;

  charger_stat_gen #(
    .BLINK_HALF(BH),
    .DEB       (DEB),
    .TERM_DLY  (TD),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .usb_i     (usb),
    .level_i   (level),
    .fault_in_i(fault_in),
    .stat_o    (stat),
    .chg_en_o  (chg_en),
    .state_o   (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int nx;
    bit old_ok;
    if (rst) begin
      m_state = 0; m_run = 0; m_ok = 1'b0; m_lvl = 0; m_age = 0;
      m_stat = 1'b1; m_chg = 1'b0;
      return;
    end
    old_ok = m_ok;
    m_run  = usb ? m_run + 1 : 0;
    m_ok   = (m_run >= DEB);
    nx     = m_state;
    case (m_state)
      0: if (old_ok) nx = fault_in ? 3 : (level ? 2 : 1);
      1: begin
        if (!old_ok)                    nx = 0;
        else if (fault_in)              nx = 3;
        else if (m_age + 1 == TMO)      nx = 3;
        else if (level && m_lvl + 1 >= TD) nx = 2;
      end
      2: begin
        if (!old_ok)                     nx = 0;
        else if (fault_in)               nx = 3;
        else if (!level && m_lvl + 1 >= TD) nx = 1;
      end
      default: if (!old_ok) nx = 0;
    endcase
    if (nx != m_state) begin
      m_age = 0;
      m_lvl = 0;
    end else begin
      m_age++;
      m_lvl = ((nx == 1 && level) || (nx == 2 && !level)) ? m_lvl + 1 : 0;
    end
    m_state = nx;
    m_chg   = (nx == 1);
    if (nx == 1)      m_stat = 1'b0;
    else if (nx == 3) m_stat = ((m_age / BH) % 2) != 0;
    else              m_stat = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("stat", 32'(stat), 32'(m_stat));
    chk("chg_en", 32'(chg_en), 32'(m_chg));
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; usb = 1'b0; level = 1'b0; fault_in = 1'b0;
    cycn(2);
    chk("reset_state", 32'(state), 0);
    chk("reset_stat", 32'(stat), 1);
    chk("reset_chg_en", 32'(chg_en), 0);

    // plug, charge, full
    rst = 1'b0; usb = 1'b1; level = 1'b0;
    cycn(3);
    chk("plug_still_off", 32'(state), 0);
    cyc();
    chk("plug_charge_state", 32'(state), 1);
    chk("plug_charge_stat", 32'(stat), 0);
    chk("plug_charge_en", 32'(chg_en), 1);
    level = 1'b1;
    cyc();
    chk("term_wait", 32'(state), 1);
    cyc();
    chk("term_done_state", 32'(state), 2);
    chk("term_done_stat", 32'(stat), 1);
    chk("term_done_en", 32'(chg_en), 0);

    // recharge with a short glitch first
    level = 1'b0; cyc();
    level = 1'b1; cyc();
    chk("glitch_stays_done", 32'(state), 2);
    level = 1'b0; cycn(2);
    chk("recharge_state", 32'(state), 1);
    chk("recharge_stat", 32'(stat), 0);

    // fault coincident with termination wins, then latches
    level = 1'b1; cyc();
    fault_in = 1'b1; cyc();
    chk("simul_fault_state", 32'(state), 3);
    chk("fault_entry_stat", 32'(stat), 0);
    chk("fault_chg_en", 32'(chg_en), 0);
    fault_in = 1'b0; level = 1'b0;
    cycn(3);
    chk("blink_low_phase", 32'(stat), 0);
    cyc();
    chk("blink_high_phase", 32'(stat), 1);
    cycn(4);
    chk("blink_latched", 32'(state), 3);
    chk("blink_low_again", 32'(stat), 0);
    usb = 1'b0; cyc();
    chk("unplug_first_edge", 32'(state), 3);
    cyc();
    chk("unplug_off_state", 32'(state), 0);
    chk("unplug_off_stat", 32'(stat), 1);

    // replug and run into the safety timeout
    usb = 1'b1; level = 1'b0;
    cycn(4);
    chk("replug_charge", 32'(state), 1);
    cycn(TMO - 1);
    chk("timeout_not_yet", 32'(state), 1);
    cyc();
    chk("timeout_fault", 32'(state), 3);
    chk("timeout_stat", 32'(stat), 0);
    chk("timeout_chg_en", 32'(chg_en), 0);
    cycn(12);

    // reset while blinking
    rst = 1'b1; cyc();
    chk("rst_fault_state", 32'(state), 0);
    chk("rst_fault_stat", 32'(stat), 1);
    chk("rst_fault_en", 32'(chg_en), 0);
    rst = 1'b0;
    cycn(3);
    chk("rst_replug_off", 32'(state), 0);
    cyc();
    chk("rst_replug_charge", 32'(state), 1);

    // plug while full
    usb = 1'b0; cycn(2);
    level = 1'b1; usb = 1'b1;
    cycn(3);
    chk("full_plug_off", 32'(state), 0);
    cyc();
    chk("full_plug_done", 32'(state), 2);
    chk("full_plug_stat", 32'(stat), 1);

    // short usb pulse is rejected
    usb = 1'b0; cycn(2);
    level = 1'b0; usb = 1'b1; cycn(2);
    usb = 1'b0; cycn(6);
    chk("usb_pulse_off", 32'(state), 0);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) usb = ~usb;
      if ($urandom_range(0, 99) < 12) level = ~level;
      fault_in = ($urandom_range(0, 299) == 0);
      rst      = ($urandom_range(0, 799) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
